vram_arbiter: RTL



---
 rtl/vram_arb_pkg.sv | 14 +
 rtl/vram_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the video RAM port-A arbiter: FSM state encoding and
// the grant identifiers used for the CPU and the loader.
package vram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates video RAM port A between the Z80 CPU and the ROM/disk loader.
// Each access is a fixed three-cycle req/ack; simultaneous requests alternate.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_din,
    output logic                     cpu_ack,
    output logic [DATA_WIDTH-1:0]    cpu_dout,

    input  logic                     ldr_req,
    input  logic                     ldr_we,
    input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0]    ldr_din,
    output logic                     ldr_ack,
    output logic [DATA_WIDTH-1:0]    ldr_dout,

    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    state_e                   state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_grant_q, last_grant_d;
    logic                     ram_we_q, ram_we_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_din_q, ram_din_d;
    logic                     cpu_ack_q, cpu_ack_d;
    logic                     ldr_ack_q, ldr_ack_d;
    logic [DATA_WIDTH-1:0]    cpu_dout_q, cpu_dout_d;
    logic [DATA_WIDTH-1:0]    ldr_dout_q, ldr_dout_d;

    logic                     cpu_elig;
    logic                     ldr_elig;
    logic                     pick;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        cpu_dout_d   = cpu_dout_q;
        ldr_dout_d   = ldr_dout_q;
        cpu_ack_d    = 1'b0;
        ldr_ack_d    = 1'b0;

        // A requester seeing its ack this cycle is finishing, not re-requesting yet.
        cpu_elig = cpu_req & ~cpu_ack_q;
        ldr_elig = ldr_req & ~ldr_ack_q;

        if (cpu_elig && ldr_elig) begin
            pick = (last_grant_q == GNT_CPU) ? GNT_LDR : GNT_CPU;
        end else if (ldr_elig) begin
            pick = GNT_LDR;
        end else begin
            pick = GNT_CPU;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_elig || ldr_elig) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    if (pick == GNT_LDR) begin
                        ram_we_d   = ldr_we;
                        ram_addr_d = ldr_addr;
                        ram_din_d  = ldr_din;
                    end else begin
                        ram_we_d   = cpu_we;
                        ram_addr_d = cpu_addr;
                        ram_din_d  = cpu_din;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                ram_we_d = 1'b0;
                state_d  = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // ram_dout now reflects the access; on writes it is the old word.
                if (grant_q == GNT_LDR) begin
                    ldr_ack_d  = 1'b1;
                    ldr_dout_d = ram_dout;
                end else begin
                    cpu_ack_d  = 1'b1;
                    cpu_dout_d = ram_dout;
                end
                state_d = ST_IDLE;
            end
            default: begin
                ram_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_LDR;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_dout_q   <= '0;
            ldr_dout_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            cpu_ack_q    <= cpu_ack_d;
            ldr_ack_q    <= ldr_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            ldr_dout_q   <= ldr_dout_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign cpu_ack  = cpu_ack_q;
    assign ldr_ack  = ldr_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign ldr_dout = ldr_dout_q;

endmodule
